pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage core. Sequences pipeline hold, bubble and flush for three events:
  - load-use hazards between D and E;
  - multi-cycle multiplies occupying E;
  - taken-branch redirects resolved in E.
- Drives the hold/flush/bubble inputs of the PC register and the FE_DE, DE_EX and EX_MEM pipeline registers. Also keeps a stall-cycle performance counter.

Parameters:
- MUL_LATENCY, 4, cycles a multiply occupies E (legal 1..15).
- LOAD_STALL_CYCLES, 2, bubbles inserted for a load-use hazard (legal 1..15).
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- reg_read_addr1_d  in  ADDR_W  rs1 of the instruction in D.
- reg_read_addr2_d  in  ADDR_W  rs2 of the instruction in D.
- rs1_used_d  in  1  instruction in D reads rs1.
- rs2_used_d  in  1  instruction in D reads rs2.
- reg_write_addr_e  in  ADDR_W  rd of the instruction in E.
- reg_write_en_e  in  1  instruction in E writes rd.
- dmem_read_en_e  in  1  instruction in E is a load.
- mul_en_e  in  1  instruction in E is a multiply.
- pc_branch_en_sel  in  1  branch/jump redirect taken in E.
- stall_pc  out  1  hold PC.
- stall_fd  out  1  hold FE_DE.
- stall_de  out  1  hold DE_EX.
- bubble_de  out  1  DE_EX loads NOP (all enables 0).
- bubble_em  out  1  EX_MEM loads NOP.
- flush_fd  out  1  clear FE_DE.
- flush_de  out  1  clear DE_EX.
- mul_busy  out  1  multiply in progress.
- ctrl_state  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MUL_WAIT.
- stall_cycles  out  32  saturating count of cycles with stall_pc=1.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM enters RUN, counter cnt (4b) = 0, stall_cycles = 0.
  - All outputs are 0 while reset is asserted and in the first RUN cycle absent inputs.
  - Reset mid-stall aborts the stall immediately. There is no resume.
- Outputs are Mealy: a function of state, cnt and the current inputs. State, cnt and stall_cycles are registered.
- load_hz is true when all of the following hold:
  - dmem_read_en_e and reg_write_en_e;
  - reg_write_addr_e != 0;
  - (rs1_used_d and reg_read_addr1_d == reg_write_addr_e) or (rs2_used_d and reg_read_addr2_d == reg_write_addr_e).
- RUN state, priority branch > mul > load:
  - pc_branch_en_sel:
    - flush_fd=1, flush_de=1 for this cycle only; stay RUN.
    - load_hz and mul_en_e are ignored this cycle.
  - else mul_en_e and MUL_LATENCY>=2:
    - stall_pc=stall_fd=stall_de=1, bubble_em=1, mul_busy=1.
    - If MUL_LATENCY==2: stay RUN, with a one-shot re-arm guard flag so the same multiply does not retrigger next cycle.
    - Otherwise go to MUL_WAIT with cnt=MUL_LATENCY-2.
  - else mul_en_e and MUL_LATENCY==1: no action.
  - else load_hz:
    - stall_pc=stall_fd=1, bubble_de=1.
    - If LOAD_STALL_CYCLES>=2, go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-2. Otherwise stay RUN.
- MUL_WAIT state:
  - mul_busy=1 throughout.
  - cnt!=0: stall_pc=stall_fd=stall_de=1, bubble_em=1, cnt decrements.
  - cnt==0: all stalls 0, so EX_MEM captures the product; go to RUN.
  - Total E occupancy is MUL_LATENCY cycles; total stall is MUL_LATENCY-1 cycles.
- LOAD_STALL state:
  - stall_pc=stall_fd=1, bubble_de=1 every cycle.
  - cnt==0: go to RUN; else cnt decrements.
  - Total bubbles = LOAD_STALL_CYCLES.
- Re-arm guard (MUL_LATENCY==2 case): the cycle after a multiply stall in RUN, mul_en_e is ignored once. In all other states the multiply is already tracked by the FSM.
- pc_branch_en_sel and mul_en_e in LOAD_STALL or MUL_WAIT: ignored. E holds a bubble or the multiply, so these are illegal. The bench flags them with an assertion.
- mul_en_e and dmem_read_en_e both set: illegal; mul wins.
- Flush and stall are never asserted in the same cycle. flush_* are never asserted outside RUN.
- stall_cycles increments on every cycle with stall_pc=1 and saturates at 0xFFFF_FFFF (no wrap).
- Hazard detection adds zero latency: stall/flush take effect on the same clock edge at which the hazard is visible.

Test Plan:
- Load-use: lw x5 in E, add x6,x5,x1 in D (rs1_used_d=1) -> stall_pc/stall_fd/bubble_de high exactly 2 cycles; ctrl_state 0→1→0; stall_cycles=2.
- x0 and unused operand: lw x0 in E with rs1=0; then lw x7 with rs2=x7 but rs2_used_d=0 -> no stall in either case.
- Multiply (MUL_LATENCY=4): mul_en_e pulse -> stall_de and bubble_em high 3 cycles, mul_busy high 4 cycles, release on the 4th; stall_cycles=3.
- Branch with simultaneous load_hz: pc_branch_en_sel=1 and load_hz=1 in the same cycle -> flush_fd=flush_de=1 for one cycle, no stall, state stays RUN.
- Reset mid-multiply: reset asserted in the 2nd MUL_WAIT cycle -> all outputs 0 asynchronously, ctrl_state=0, stall_cycles=0.
- Saturation: preload stall_cycles to 0xFFFF_FFFE via a forced sequence, then 3 stall cycles -> holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central hazard controller for the 5-stage core. It sequences hold, bubble
//   and flush controls for three events: load-use hazards between D and E,
//   multi-cycle multiplies occupying E, and taken-branch redirects resolved
//   in E. Outputs are Mealy: a function of state, cnt and the current inputs.
//   State, cnt, the re-arm guard and the stall counter are registered.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   reg_read_addr1/2_d  : rs1/rs2 of the instruction in D
//   rs1/rs2_used_d      : instruction in D actually reads rs1/rs2
//   reg_write_addr_e    : rd of the instruction in E
//   reg_write_en_e      : instruction in E writes rd
//   dmem_read_en_e      : instruction in E is a load
//   mul_en_e            : instruction in E is a multiply
//   pc_branch_en_sel    : branch/jump redirect taken in E
//   stall_pc/fd/de      : hold PC, FE_DE, DE_EX
//   bubble_de/em        : DE_EX / EX_MEM load a NOP
//   flush_fd/de         : clear FE_DE / DE_EX
//   mul_busy            : multiply in progress
//   ctrl_state          : 0 RUN, 1 LOAD_STALL, 2 MUL_WAIT
//   stall_cycles        : saturating count of cycles with stall_pc=1
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY       = 4,
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int ADDR_W            = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reg_read_addr1_d,
  input  logic [ADDR_W-1:0] reg_read_addr2_d,
  input  logic              rs1_used_d,
  input  logic              rs2_used_d,
  input  logic [ADDR_W-1:0] reg_write_addr_e,
  input  logic              reg_write_en_e,
  input  logic              dmem_read_en_e,
  input  logic              mul_en_e,
  input  logic              pc_branch_en_sel,
  output logic              stall_pc,
  output logic              stall_fd,
  output logic              stall_de,
  output logic              bubble_de,
  output logic              bubble_em,
  output logic              flush_fd,
  output logic              flush_de,
  output logic              mul_busy,
  output logic [1:0]        ctrl_state,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MUL_WAIT   = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_rearm;
  logic [31:0] r_stall_cycles;

  state_t      w_next_state;
  logic [3:0]  w_next_cnt;
  logic        w_next_rearm;
  logic        w_load_hz;
  logic        w_stall_pc;
  logic        w_stall_fd;
  logic        w_stall_de;
  logic        w_bubble_de;
  logic        w_bubble_em;
  logic        w_flush_fd;
  logic        w_flush_de;
  logic        w_mul_busy;

  assign w_load_hz = dmem_read_en_e && reg_write_en_e &&
                     (reg_write_addr_e != '0) &&
                     ((rs1_used_d && (reg_read_addr1_d == reg_write_addr_e)) ||
                      (rs2_used_d && (reg_read_addr2_d == reg_write_addr_e)));

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_rearm = 1'b0;
    w_stall_pc   = 1'b0;
    w_stall_fd   = 1'b0;
    w_stall_de   = 1'b0;
    w_bubble_de  = 1'b0;
    w_bubble_em  = 1'b0;
    w_flush_fd   = 1'b0;
    w_flush_de   = 1'b0;
    w_mul_busy   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (pc_branch_en_sel) begin
          w_flush_fd = 1'b1;
          w_flush_de = 1'b1;
        end else if (mul_en_e && !r_rearm && (MUL_LATENCY >= 2)) begin
          w_stall_pc  = 1'b1;
          w_stall_fd  = 1'b1;
          w_stall_de  = 1'b1;
          w_bubble_em = 1'b1;
          w_mul_busy  = 1'b1;
          if (MUL_LATENCY == 2) begin
            w_next_rearm = 1'b1;
          end else begin
            w_next_state = MUL_WAIT;
            w_next_cnt   = 4'(MUL_LATENCY - 2);
          end
        end else if (mul_en_e) begin
          // Single-cycle multiply, or the re-armed cycle of a 2-cycle one:
          // the multiply still owns E, so it also masks any load hazard.
        end else if (w_load_hz) begin
          w_stall_pc  = 1'b1;
          w_stall_fd  = 1'b1;
          w_bubble_de = 1'b1;
          if (LOAD_STALL_CYCLES >= 2) begin
            w_next_state = LOAD_STALL;
            w_next_cnt   = 4'(LOAD_STALL_CYCLES - 2);
          end
        end
      end
      LOAD_STALL: begin
        w_stall_pc  = 1'b1;
        w_stall_fd  = 1'b1;
        w_bubble_de = 1'b1;
        if (r_cnt == '0) w_next_state = RUN;
        else             w_next_cnt   = r_cnt - 4'd1;
      end
      MUL_WAIT: begin
        w_mul_busy = 1'b1;
        if (r_cnt != '0) begin
          w_stall_pc  = 1'b1;
          w_stall_fd  = 1'b1;
          w_stall_de  = 1'b1;
          w_bubble_em = 1'b1;
          w_next_cnt  = r_cnt - 4'd1;
        end else begin
          // Stalls drop so EX_MEM captures the finished product.
          w_next_state = RUN;
        end
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_rearm        <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_rearm <= w_next_rearm;
      if (w_stall_pc && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_pc     = w_stall_pc;
  assign stall_fd     = w_stall_fd;
  assign stall_de     = w_stall_de;
  assign bubble_de    = w_bubble_de;
  assign bubble_em    = w_bubble_em;
  assign flush_fd     = w_flush_fd;
  assign flush_de     = w_flush_de;
  assign mul_busy     = w_mul_busy;
  assign ctrl_state   = r_state;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed-vector bench for pipeline_hazard_ctrl with default parameters
//   (MUL_LATENCY=4, LOAD_STALL_CYCLES=2, ADDR_W=5). Inputs change on the
//   falling edge; outputs are checked 1 time unit later.
//   Output vector order used in checks:
//   {stall_pc, stall_fd, stall_de, bubble_de, bubble_em, flush_fd, flush_de, mul_busy}
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LOAD = 8'b1101_0000;
  localparam logic [7:0] O_MUL  = 8'b1110_1001;
  localparam logic [7:0] O_MREL = 8'b0000_0001;
  localparam logic [7:0] O_FLSH = 8'b0000_0110;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  reg_read_addr1_d;
  logic [4:0]  reg_read_addr2_d;
  logic        rs1_used_d;
  logic        rs2_used_d;
  logic [4:0]  reg_write_addr_e;
  logic        reg_write_en_e;
  logic        dmem_read_en_e;
  logic        mul_en_e;
  logic        pc_branch_en_sel;
  logic        stall_pc;
  logic        stall_fd;
  logic        stall_de;
  logic        bubble_de;
  logic        bubble_em;
  logic        flush_fd;
  logic        flush_de;
  logic        mul_busy;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pipeline_hazard_ctrl #(
    .MUL_LATENCY      (4),
    .LOAD_STALL_CYCLES(2),
    .ADDR_W           (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .reg_read_addr1_d(reg_read_addr1_d),
    .reg_read_addr2_d(reg_read_addr2_d),
    .rs1_used_d      (rs1_used_d),
    .rs2_used_d      (rs2_used_d),
    .reg_write_addr_e(reg_write_addr_e),
    .reg_write_en_e  (reg_write_en_e),
    .dmem_read_en_e  (dmem_read_en_e),
    .mul_en_e        (mul_en_e),
    .pc_branch_en_sel(pc_branch_en_sel),
    .stall_pc        (stall_pc),
    .stall_fd        (stall_fd),
    .stall_de        (stall_de),
    .bubble_de       (bubble_de),
    .bubble_em       (bubble_em),
    .flush_fd        (flush_fd),
    .flush_de        (flush_de),
    .mul_busy        (mul_busy),
    .ctrl_state      (ctrl_state),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Branch or multiply while E holds a bubble/multiply is illegal stimulus.
  always @(posedge clk) begin
    if (!reset && ctrl_state != 2'd0)
      chk("no_br_mul_in_stall", {30'd0, pc_branch_en_sel, mul_en_e}, 32'd0);
  end

  function automatic logic [7:0] outs();
    return {stall_pc, stall_fd, stall_de, bubble_de, bubble_em, flush_fd, flush_de, mul_busy};
  endfunction

  // Drive one cycle of inputs on the falling edge.
  task automatic drive(input logic [4:0] ra1, input logic u1, input logic [4:0] ra2,
                       input logic u2, input logic [4:0] wa, input logic we,
                       input logic rd, input logic mul, input logic br);
    @(negedge clk);
    reg_read_addr1_d = ra1;
    rs1_used_d       = u1;
    reg_read_addr2_d = ra2;
    rs2_used_d       = u2;
    reg_write_addr_e = wa;
    reg_write_en_e   = we;
    dmem_read_en_e   = rd;
    mul_en_e         = mul;
    pc_branch_en_sel = br;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_cyc(input string tag, input logic [7:0] o, input logic [1:0] st,
                            input logic [31:0] sc);
    chk({tag, "_outs"},  {24'd0, outs()},    {24'd0, o});
    chk({tag, "_state"}, {30'd0, ctrl_state}, {30'd0, st});
    chk({tag, "_sc"},    stall_cycles,        sc);
  endtask

  initial begin
    reset = 1'b1;
    reg_read_addr1_d = '0; reg_read_addr2_d = '0;
    rs1_used_d = 1'b0; rs2_used_d = 1'b0;
    reg_write_addr_e = '0; reg_write_en_e = 1'b0;
    dmem_read_en_e = 1'b0; mul_en_e = 1'b0; pc_branch_en_sel = 1'b0;
    #2;
    expect_cyc("reset", O_IDLE, 2'd0, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    idle();                   expect_cyc("run0", O_IDLE, 2'd0, 32'd0);

    // lw x5 in E, add x6,x5,x1 in D
    drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_cyc("lu1_c0", O_LOAD, 2'd0, 32'd0);
    drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cyc("lu1_c1", O_LOAD, 2'd1, 32'd1);
    idle();                   expect_cyc("lu1_c2", O_IDLE, 2'd0, 32'd2);

    // lw x0 with rs1=x0: no hazard
    drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_cyc("x0", O_IDLE, 2'd0, 32'd2);
    // lw x7, rs2=x7 but unused
    drive(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_cyc("unused", O_IDLE, 2'd0, 32'd2);
    // ALU producer of x7 (not a load): forwarded, no stall
    drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_cyc("noload", O_IDLE, 2'd0, 32'd2);

    // lw x7, rs2=x7 used
    drive(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_cyc("lu2_c0", O_LOAD, 2'd0, 32'd2);
    drive(5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cyc("lu2_c1", O_LOAD, 2'd1, 32'd3);
    idle();                   expect_cyc("lu2_c2", O_IDLE, 2'd0, 32'd4);

    // multiply with a conflicting load hazard: mul wins
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_cyc("mul_c0", O_MUL,  2'd0, 32'd4);
    idle();                   expect_cyc("mul_c1", O_MUL,  2'd2, 32'd5);
    idle();                   expect_cyc("mul_c2", O_MUL,  2'd2, 32'd6);
    idle();                   expect_cyc("mul_c3", O_MREL, 2'd2, 32'd7);
    idle();                   expect_cyc("mul_c4", O_IDLE, 2'd0, 32'd7);

    // branch with simultaneous load hazard
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    expect_cyc("br_c0", O_FLSH, 2'd0, 32'd7);
    idle();                   expect_cyc("br_c1", O_IDLE, 2'd0, 32'd7);

    // reset in the 2nd MUL_WAIT cycle
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_cyc("rm_c0", O_MUL, 2'd0, 32'd7);
    idle();                   expect_cyc("rm_c1", O_MUL, 2'd2, 32'd8);
    idle();                   expect_cyc("rm_c2", O_MUL, 2'd2, 32'd9);
    reset = 1'b1;
    #1;
    expect_cyc("rm_rst", O_IDLE, 2'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();                   expect_cyc("rm_run", O_IDLE, 2'd0, 32'd0);

    // saturation: preload counter near the top, then 3 multiply stall cycles
    @(negedge clk);
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cycles;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_cyc("sat_c0", O_MUL,  2'd0, 32'hFFFF_FFFE);
    idle();                   expect_cyc("sat_c1", O_MUL,  2'd2, 32'hFFFF_FFFF);
    idle();                   expect_cyc("sat_c2", O_MUL,  2'd2, 32'hFFFF_FFFF);
    idle();                   expect_cyc("sat_c3", O_MREL, 2'd2, 32'hFFFF_FFFF);
    idle();                   expect_cyc("sat_c4", O_IDLE, 2'd0, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
